// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   if_*                  fetch read port (request, address, data, valid, hold)
//   dm_*                  data port (read/write request, width, address,
//                         store data, load data, valid, hold)
//   mem_*                 registered memory strobes, width, address and
//                         write data; mem_rdata_in is the read data return
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int RR      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_valid_out,
  output logic              if_hold_out,
  input  logic              dm_re_in,
  input  logic              dm_we_in,
  input  logic [1:0]        dm_width_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [DATA_W-1:0] dm_wdata_in,
  output logic [DATA_W-1:0] dm_rdata_out,
  output logic              dm_valid_out,
  output logic              dm_hold_out,
  output logic              mem_re_out,
  output logic              mem_we_out,
  output logic [1:0]        mem_width_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic {
    G_IF,
    G_DM
  } grant_t;

  state_t           state;
  state_t           state_nx;
  grant_t           grant;
  grant_t           last_grant;
  grant_t           pick;
  logic [CNT_W-1:0] cnt;
  logic             op_we;
  logic             if_req;
  logic             dm_req;

  assign if_req = if_re_in;
  assign dm_req = dm_re_in | dm_we_in;

  // Tie break: round-robin alternates away from the last winner,
  // otherwise the data port always wins.
  always_comb begin
    pick = G_IF;
    unique case (1'b1)
      (if_req && dm_req): begin
        if (RR != 0 && last_grant == G_DM)
          pick = G_IF;
        else
          pick = G_DM;
      end
      (dm_req && !if_req): pick = G_DM;
      default:             pick = G_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    if_valid_out = 1'b0;
    dm_valid_out = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (if_req || dm_req)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = op_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0)
          state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx     = S_IDLE;
        if_valid_out = (grant == G_IF);
        dm_valid_out = (grant == G_DM);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign if_hold_out = if_req &
    ~(state == S_DONE && grant == G_IF);
  assign dm_hold_out = dm_req &
    ~(state == S_DONE && grant == G_DM);

  // Strobes and width are only non-zero for the single ISSUE cycle;
  // address and write data simply hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_re_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_width_out <= '0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      if_data_out   <= '0;
      dm_rdata_out  <= '0;
      grant         <= G_IF;
      last_grant    <= G_DM;
      op_we         <= 1'b0;
      cnt           <= '0;
    end else begin
      mem_re_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_width_out <= '0;
      unique case (state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            grant <= pick;
            if (pick == G_DM) begin
              // read+write together is taken as a write
              op_we         <= dm_we_in;
              mem_re_out    <= ~dm_we_in;
              mem_we_out    <= dm_we_in;
              mem_width_out <= dm_width_in;
              mem_addr_out  <= dm_addr_in;
              mem_wdata_out <= dm_wdata_in;
            end else begin
              op_we         <= 1'b0;
              mem_re_out    <= 1'b1;
              mem_width_out <= 2'b10;
              mem_addr_out  <= if_addr_in;
            end
          end
        end
        S_ISSUE: begin
          cnt <= CNT_W'(MEM_LAT - 1);
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (grant == G_IF)
              if_data_out <= mem_rdata_in;
            else
              dm_rdata_out <= mem_rdata_in;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter.
// Transaction-level model: arbitration rule, latency and data per port.
module tb_mem_arbiter;

  localparam int MEM_LAT = 3;
  localparam int RR      = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_re_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic [31:0] if_data_out;
  logic        if_valid_out;
  logic        if_hold_out;
  logic        dm_re_in = 1'b0;
  logic        dm_we_in = 1'b0;
  logic [1:0]  dm_width_in = '0;
  logic [31:0] dm_addr_in = '0;
  logic [31:0] dm_wdata_in = '0;
  logic [31:0] dm_rdata_out;
  logic        dm_valid_out;
  logic        dm_hold_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [1:0]  mem_width_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in = '0;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_last_dm = 1'b1;
  logic [31:0] m_if = '0;
  logic [31:0] m_dm = '0;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(MEM_LAT),
    .RR     (RR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_re_in     (if_re_in),
    .if_addr_in   (if_addr_in),
    .if_data_out  (if_data_out),
    .if_valid_out (if_valid_out),
    .if_hold_out  (if_hold_out),
    .dm_re_in     (dm_re_in),
    .dm_we_in     (dm_we_in),
    .dm_width_in  (dm_width_in),
    .dm_addr_in   (dm_addr_in),
    .dm_wdata_in  (dm_wdata_in),
    .dm_rdata_out (dm_rdata_out),
    .dm_valid_out (dm_valid_out),
    .dm_hold_out  (dm_hold_out),
    .mem_re_out   (mem_re_out),
    .mem_we_out   (mem_we_out),
    .mem_width_out(mem_width_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in (mem_rdata_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100)
      return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Memory model: data appears MEM_LAT cycles after the read strobe;
  // any other cycle carries noise.
  logic        rd_v [1:MEM_LAT];
  logic [31:0] rd_a [1:MEM_LAT];

  initial
    for (int i = 1; i <= MEM_LAT; i++) begin
      rd_v[i] = 1'b0;
      rd_a[i] = '0;
    end

  always @(posedge clk) begin
    rd_v[1] <= mem_re_out;
    rd_a[1] <= mem_addr_out;
    for (int i = 2; i <= MEM_LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
  end

  always @(negedge clk)
    mem_rdata_in = rd_v[MEM_LAT] ? mem_word(rd_a[MEM_LAT]) : $urandom;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called mid-cycle in the cycle the arbiter samples its requests.
  // Ends mid-cycle in the following idle cycle.
  task automatic txn(input bit drop_mid, input bit scramble,
                     output bit win_dm);
    bit          ifr, dmr, is_rd;
    logic [31:0] a, wd;
    logic [1:0]  wdt;
    int          done;
    ifr = if_re_in;
    dmr = dm_re_in | dm_we_in;
    if (ifr && dmr)
      win_dm = (RR != 0) ? !m_last_dm : 1'b1;
    else
      win_dm = dmr;
    is_rd = win_dm ? !dm_we_in : 1'b1;
    a     = win_dm ? dm_addr_in : if_addr_in;
    wdt   = win_dm ? dm_width_in : 2'b10;
    wd    = dm_wdata_in;
    done  = is_rd ? 2 + MEM_LAT : 2;
    #1;
    chk("hold_if_c0", if_hold_out, ifr);
    chk("hold_dm_c0", dm_hold_out, dmr);
    for (int k = 1; k <= done; k++) begin
      @(negedge clk);
      if (k == 1 && scramble) begin
        if (win_dm) begin
          dm_addr_in  = $urandom;
          dm_wdata_in = $urandom;
          dm_width_in = 2'($urandom);
        end else begin
          if_addr_in = $urandom;
        end
      end
      if (k == 2 && drop_mid) begin
        if (win_dm) begin
          dm_re_in = 1'b0;
          dm_we_in = 1'b0;
        end else begin
          if_re_in = 1'b0;
        end
      end
      #1;
      chk("mem_re", mem_re_out, k == 1 && is_rd);
      chk("mem_we", mem_we_out, k == 1 && !is_rd);
      if (k == 1) begin
        chk("mem_addr", mem_addr_out, a);
        chk("mem_width", mem_width_out, wdt);
        if (!is_rd)
          chk("mem_wdata", mem_wdata_out, wd);
      end else begin
        chk("mem_width_idle", mem_width_out, 2'b00);
      end
      if (k == done && is_rd) begin
        if (win_dm)
          m_dm = mem_word(a);
        else
          m_if = mem_word(a);
      end
      chk("if_valid", if_valid_out, k == done && !win_dm);
      chk("dm_valid", dm_valid_out, k == done && win_dm);
      chk("if_data", if_data_out, m_if);
      chk("dm_rdata", dm_rdata_out, m_dm);
      chk("if_hold", if_hold_out,
          if_re_in && !(k == done && !win_dm));
      chk("dm_hold", dm_hold_out,
          (dm_re_in | dm_we_in) && !(k == done && win_dm));
    end
    m_last_dm = win_dm;
    @(negedge clk);
    #1;
    chk("idle_re", mem_re_out, 1'b0);
    chk("idle_we", mem_we_out, 1'b0);
    chk("idle_if_valid", if_valid_out, 1'b0);
    chk("idle_dm_valid", dm_valid_out, 1'b0);
  endtask

  task automatic clear_reqs();
    if_re_in = 1'b0;
    dm_re_in = 1'b0;
    dm_we_in = 1'b0;
  endtask

  task automatic new_dm();
    int op;
    op          = $urandom_range(0, 3);
    dm_re_in    = (op == 1) || (op == 3);
    dm_we_in    = (op >= 2);
    dm_width_in = 2'($urandom);
    dm_addr_in  = $urandom;
    dm_wdata_in = $urandom;
  endtask

  task automatic new_if();
    if_re_in   = 1'($urandom_range(0, 1));
    if_addr_in = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    bit w;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_re", mem_re_out, 1'b0);
    chk("rst_we", mem_we_out, 1'b0);
    chk("rst_width", mem_width_out, 2'b00);
    chk("rst_addr", mem_addr_out, 32'h0);
    chk("rst_wdata", mem_wdata_out, 32'h0);
    chk("rst_if_valid", if_valid_out, 1'b0);
    chk("rst_dm_valid", dm_valid_out, 1'b0);
    chk("rst_if_data", if_data_out, 32'h0);
    chk("rst_dm_data", dm_rdata_out, 32'h0);
    chk("rst_if_hold", if_hold_out, 1'b0);
    chk("rst_dm_hold", dm_hold_out, 1'b0);

    // fetch held through reset issues right after release
    if_re_in   = 1'b1;
    if_addr_in = 32'h0000_1000;
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 1'b0, w);
    clear_reqs();

    // load from 0x100
    dm_re_in   = 1'b1;
    dm_addr_in = 32'h100;
    dm_width_in = 2'b10;
    txn(1'b0, 1'b0, w);
    clear_reqs();

    // byte store
    dm_we_in    = 1'b1;
    dm_width_in = 2'b00;
    dm_addr_in  = 32'h203;
    dm_wdata_in = 32'hAB;
    txn(1'b0, 1'b0, w);
    clear_reqs();

    // simultaneous requests, repeated
    for (int r = 0; r < 4; r++) begin
      if_re_in   = 1'b1;
      if_addr_in = 32'h2000 + 32'(r * 4);
      dm_re_in   = 1'b1;
      dm_addr_in = 32'h3000 + 32'(r * 4);
      txn(1'b0, 1'b0, w);
    end
    clear_reqs();

    // read and write at once behaves as a write
    dm_re_in    = 1'b1;
    dm_we_in    = 1'b1;
    dm_addr_in  = 32'h44;
    dm_wdata_in = 32'h5555_AAAA;
    txn(1'b0, 1'b0, w);
    clear_reqs();

    // reset during the wait phase of a read
    dm_re_in   = 1'b1;
    dm_addr_in = 32'h80;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    m_if = '0;
    m_dm = '0;
    m_last_dm = 1'b1;
    chk("midrst_re", mem_re_out, 1'b0);
    chk("midrst_we", mem_we_out, 1'b0);
    chk("midrst_valid", dm_valid_out, 1'b0);
    chk("midrst_data", dm_rdata_out, 32'h0);
    chk("midrst_hold", dm_hold_out, 1'b1);
    repeat (MEM_LAT + 1) begin
      @(negedge clk);
      #1;
      chk("midrst_novalid", dm_valid_out, 1'b0);
    end
    rst = 1'b0;
    txn(1'b0, 1'b0, w);
    clear_reqs();

    // random traffic
    new_if();
    new_dm();
    for (int r = 0; r < 300; r++) begin
      if (!if_re_in && !(dm_re_in | dm_we_in)) begin
        if_re_in   = 1'b1;
        if_addr_in = $urandom & 32'hFFFF_FFFC;
      end
      txn(1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), w);
      if (w)
        new_dm();
      else
        new_if();
      if (!if_re_in)
        new_if();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
